// File: rtl/cic_decim_ctrl.sv
// Sequencing controller for a third-order CIC decimator: comb strobes, clear/settle
// sequencing, output alignment and a valid/ready result register with overrun flag.
module cic_decim_ctrl #(
  parameter int NUMBITS  = 25,
  parameter int SETTLE_N = 3
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [1:0]         i_dec_sel,
  input  logic               i_cfg_load,
  input  logic [NUMBITS-1:0] i_comb_result,
  output logic               o_cic_clear,
  output logic               o_comb_strobe,
  output logic [NUMBITS-1:0] o_dout,
  output logic               o_dout_valid,
  input  logic               i_dout_ready,
  output logic               o_overrun,
  output logic               o_settled
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SETTLE, S_RUN} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [7:0]   r_phase;
  logic [1:0]   r_settle_cnt;
  logic [1:0]   r_act_sel;
  logic         r_cap_pend_p1;
  logic [7:0]   w_phase_last;
  logic         w_counting;
  logic         w_strobe;
  logic         w_capture;

  // Last phase index of a decimation period: D-1 for D = 32 << sel.
  function automatic logic [7:0] phase_last(input logic [1:0] sel);
    return 8'((9'd32 << sel) - 9'd1);
  endfunction

  // Left-align so full scale D^3 lands on 2^24 regardless of ratio.
  function automatic logic [NUMBITS-1:0] align_sample(input logic [NUMBITS-1:0] res,
                                                      input logic [1:0] sel);
    logic [NUMBITS-1:0] v;
    case (sel)
      2'd0:    v = res << 9;
      2'd1:    v = res << 6;
      2'd2:    v = res << 3;
      default: v = res;
    endcase
    return v;
  endfunction

  assign w_phase_last = phase_last(r_act_sel);
  assign w_counting   = (r_state == S_SETTLE) || (r_state == S_RUN);
  assign w_strobe     = w_counting && (r_phase == w_phase_last);
  assign w_capture    = r_cap_pend_p1 && (r_state == S_RUN) && i_enable && !i_cfg_load;

  always_comb begin
    w_state_nxt   = r_state;
    o_cic_clear   = (r_state == S_CLEAR);
    o_comb_strobe = w_strobe;
    o_settled     = (r_state == S_RUN);
    if (r_state == S_IDLE) begin
      if (i_enable) w_state_nxt = S_CLEAR;
    end else if (!i_enable) begin
      w_state_nxt = S_IDLE;
    end else if (i_cfg_load) begin
      w_state_nxt = S_CLEAR;
    end else begin
      case (r_state)
        S_CLEAR:  w_state_nxt = S_SETTLE;
        S_SETTLE: if (w_strobe && (r_settle_cnt == 2'(SETTLE_N - 1))) w_state_nxt = S_RUN;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_act_sel     <= 2'd3;
      r_phase       <= 8'd0;
      r_settle_cnt  <= 2'd0;
      r_cap_pend_p1 <= 1'b0;
      o_dout        <= '0;
      o_dout_valid  <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (i_cfg_load && ((r_state == S_IDLE) || i_enable)) r_act_sel <= i_dec_sel;

      if (r_state == S_CLEAR) begin
        r_phase      <= 8'd0;
        r_settle_cnt <= 2'd0;
      end else if (w_counting) begin
        r_phase <= (r_phase == w_phase_last) ? 8'd0 : r_phase + 8'd1;
        if (w_strobe && (r_state == S_SETTLE)) r_settle_cnt <= r_settle_cnt + 2'd1;
      end

      // Stage p1: comb register updated by the strobe, sampled here one cycle later.
      r_cap_pend_p1 <= w_strobe && (r_state == S_RUN) && i_enable && !i_cfg_load;

      // Stage p2: aligned result register with handshake; capture beats consumption.
      if ((r_state != S_IDLE) && !i_enable) begin
        o_dout_valid <= 1'b0;
      end else if (r_state == S_CLEAR) begin
        o_dout_valid <= 1'b0;
        o_overrun    <= 1'b0;
      end else if (w_capture) begin
        o_dout       <= align_sample(i_comb_result, r_act_sel);
        o_dout_valid <= 1'b1;
        if (o_dout_valid && !i_dout_ready) o_overrun <= 1'b1;
      end else if (o_dout_valid && i_dout_ready) begin
        o_dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Self-checking bench for cic_decim_ctrl: directed scenarios with random data, compared
// each cycle against a timing model expressed as offsets from the last clear cycle.
module tb_cic_decim_ctrl;
  localparam int NB = 25;

  logic          clk = 1'b0;
  logic          reset, enable, cfg_load, dout_ready;
  logic [1:0]    dec_sel;
  logic [NB-1:0] comb_result;
  logic          cic_clear, comb_strobe, dout_valid, overrun, settled;
  logic [NB-1:0] dout;

  int checks   = 0;
  int failures = 0;

  // Reference state: cycle index, whether the filter is running, and the clear cycle.
  int            cyc      = 0;
  bit            m_active = 1'b0;
  int            m_c      = 0;
  int            m_sel    = 3;
  logic [NB-1:0] m_dout   = '0;
  bit            m_valid  = 1'b0;
  bit            m_ovr    = 1'b0;

  always #5 clk = ~clk;

  cic_decim_ctrl #(.NUMBITS(NB), .SETTLE_N(3)) u_dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_enable      (enable),
    .i_dec_sel     (dec_sel),
    .i_cfg_load    (cfg_load),
    .i_comb_result (comb_result),
    .o_cic_clear   (cic_clear),
    .o_comb_strobe (comb_strobe),
    .o_dout        (dout),
    .o_dout_valid  (dout_valid),
    .i_dout_ready  (dout_ready),
    .o_overrun     (overrun),
    .o_settled     (settled)
  );

  function automatic int ratio(input int sel);
    return 32 << sel;
  endfunction

  // Full scale D^3 maps to 2^24, so the gain is 2^24 / D^3.
  function automatic logic [NB-1:0] scale(input logic [NB-1:0] r, input int sel);
    longint d, f;
    d = longint'(ratio(sel));
    f = (longint'(1) << 24) / (d * d * d);
    return NB'(longint'(r) * f);
  endfunction

  // The cycle after the 4th and later strobes since the clear carries a capture.
  function automatic bit cap_now();
    int t, d;
    t = cyc - m_c;
    d = ratio(m_sel);
    return m_active && (t >= 4 * d + 1) && ((t - 1) % d == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int t, d;
    t = cyc - m_c;
    d = ratio(m_sel);
    chk("cic_clear",   32'(cic_clear),   32'(m_active && t == 0));
    chk("comb_strobe", 32'(comb_strobe), 32'(m_active && t > 0 && (t % d) == 0));
    chk("settled",     32'(settled),     32'(m_active && t > 3 * d));
    chk("dout",        32'(dout),        32'(m_dout));
    chk("dout_valid",  32'(dout_valid),  32'(m_valid));
    chk("overrun",     32'(overrun),     32'(m_ovr));
  endtask

  task automatic model_update();
    bit cap;
    int t;
    cap = cap_now();
    t   = cyc - m_c;
    if (reset) begin
      m_active = 1'b0; m_sel = 3; m_dout = '0; m_valid = 1'b0; m_ovr = 1'b0;
    end else if (!m_active) begin
      if (cfg_load) m_sel = int'(dec_sel);
      if (m_valid && dout_ready) m_valid = 1'b0;
      if (enable) begin m_active = 1'b1; m_c = cyc + 1; end
    end else if (!enable) begin
      m_active = 1'b0; m_valid = 1'b0;
    end else begin
      if (cfg_load) begin m_sel = int'(dec_sel); m_c = cyc + 1; end
      if (t == 0) begin
        m_valid = 1'b0; m_ovr = 1'b0;
      end else if (cap && !cfg_load) begin
        if (m_valid && !dout_ready) m_ovr = 1'b1;
        m_dout  = scale(comb_result, m_sel);
        m_valid = 1'b1;
      end else if (m_valid && dout_ready) begin
        m_valid = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) begin
      comb_result = NB'($urandom);
      tick();
    end
  endtask

  task automatic load(input logic [1:0] sel);
    dec_sel = sel; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; cfg_load = 1'b0; dout_ready = 1'b1;
    dec_sel = 2'd0; comb_result = '0;
    @(posedge clk); #1;

    // Reset held with enable high, then default D256 sequencing.
    run(5);
    reset = 1'b0;
    run(900);

    // D32 from IDLE: 0x008000 aligns to 0x1000000.
    enable = 1'b0; tick();
    load(2'd0);
    enable = 1'b1; comb_result = NB'(32'h008000);
    run(4 * 32 + 2 + 3 * 32);
    run_rand(100);

    // Full-scale checks at D256 and D128.
    comb_result = NB'(32'h1000000);
    load(2'd3);
    run(4 * 256 + 2 + 20);
    comb_result = NB'(32'h200000);
    load(2'd2);
    run(4 * 128 + 2 + 140);

    // Backpressure across captures, then ready only in capture cycles.
    dout_ready = 1'b0;
    load(2'd0);
    run_rand(4 * 32 + 2 + 2 * 32 + 5);
    load(2'd0);
    for (int i = 0; i < 4 * 32 + 2 + 4 * 32; i++) begin
      dout_ready  = cap_now();
      comb_result = NB'($urandom);
      tick();
    end

    // Random traffic with occasional reconfiguration and single-cycle disables.
    for (int i = 0; i < 3000; i++) begin
      comb_result = NB'($urandom);
      dout_ready  = 1'($urandom_range(0, 1));
      cfg_load    = ($urandom_range(0, 499) == 0);
      dec_sel     = 2'($urandom_range(0, 1));
      enable      = ($urandom_range(0, 999) != 0);
      tick();
    end
    enable = 1'b1; cfg_load = 1'b0; dout_ready = 1'b0;

    // Reconfigure to D256 while a capture is pending.
    load(2'd0);
    for (int i = 0; i < 300 && !cap_now(); i++) run_rand(1);
    chk("capture_reached", 32'(cap_now()), 32'd1);
    load(2'd3);
    dout_ready = 1'b1;
    run_rand(4 * 256 + 2 + 10);

    // Disable during SETTLE, then reset pulse mid-RUN.
    load(2'd0);
    run_rand(50);
    enable = 1'b0;
    run_rand(100);
    enable = 1'b1;
    run_rand(4 * 32 + 40);
    reset = 1'b1; tick();
    reset = 1'b0; enable = 1'b0;
    run_rand(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
